// File: rtl/dehaze_pass_sequencer.sv
// dehaze_pass_sequencer
//
// Runs the two-pass dehaze flow over one stored frame. Pass 1 streams the
// whole frame from the frame buffer into atmospheric light estimation (ALE)
// with te_en=0 and then waits for ALE's done flag. Pass 2 raises te_en,
// streams the same frame again into transmission estimation (TE) and counts
// the transmission beats until all N have been seen.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   start         frame request, only honoured in IDLE
//   abort         synchronous abort back to IDLE from any busy state
//   mem_rd_en     frame-buffer read strobe
//   mem_rd_addr   linear read address 0..N-1
//   mem_rd_data   {R,G,B}, valid the cycle after mem_rd_en
//   pixel_out     pixel to ALE_TE_Top (mem_rd_data while pixel_valid)
//   pixel_valid   mem_rd_en delayed by one cycle
//   te_en         0 = ALE pass, 1 = TE pass
//   ale_done      ALE done flag
//   trans_valid   TE transmission output strobe
//   busy          high in every state except IDLE
//   frame_done    one-cycle pulse on successful completion
//   error         sticky timeout flag, cleared by the next accepted start
//   out_count     transmission beats counted in the current pass 2
module dehaze_pass_sequencer #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int ADDR_W     = 18,
    parameter int ARM_CYCLES = 2,
    parameter int TIMEOUT    = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [23:0]       mem_rd_data,
    output logic [23:0]       pixel_out,
    output logic              pixel_valid,
    output logic              te_en,
    input  logic              ale_done,
    input  logic              trans_valid,
    output logic              busy,
    output logic              frame_done,
    output logic              error,
    output logic [ADDR_W:0]   out_count
);

    localparam int N       = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_MAX = (TIMEOUT > ARM_CYCLES) ? TIMEOUT : ARM_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(N);
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  ARM_LAST  = CNT_W'(ARM_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALE_PASS,
        S_ALE_WAIT,
        S_TE_ARM,
        S_TE_PASS,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cyc_cnt;
    logic             vld_p1;
    logic             te_window;

    // trans_valid only means something while TE is being fed or draining
    assign te_window = (state == S_TE_ARM) || (state == S_TE_PASS) || (state == S_DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cyc_cnt     <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            te_en       <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            error       <= 1'b0;
            out_count   <= '0;
        end else begin
            frame_done <= 1'b0;

            if (te_window && trans_valid && (out_count != FULL_CNT))
                out_count <= out_count + (ADDR_W + 1)'(1);

            if (abort && (state != S_IDLE)) begin
                // abort wins over every other transition; error is left as is
                state       <= S_IDLE;
                mem_rd_en   <= 1'b0;
                mem_rd_addr <= '0;
                te_en       <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        te_en <= 1'b0;
                        if (start) begin
                            state       <= S_ALE_PASS;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= '0;
                            busy        <= 1'b1;
                            error       <= 1'b0;
                            out_count   <= '0;
                        end
                    end

                    S_ALE_PASS: begin
                        if (mem_rd_addr == LAST_ADDR) begin
                            state       <= S_ALE_WAIT;
                            mem_rd_en   <= 1'b0;
                            mem_rd_addr <= '0;
                            cyc_cnt     <= '0;
                        end else begin
                            mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
                        end
                    end

                    S_ALE_WAIT: begin
                        // the first wait cycle still carries the final pass-1
                        // beat, so ALE cannot legitimately be done yet
                        if (ale_done && (cyc_cnt != '0)) begin
                            state   <= S_TE_ARM;
                            te_en   <= 1'b1;
                            cyc_cnt <= '0;
                        end else if (cyc_cnt == TMO_LAST) begin
                            state <= S_IDLE;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            cyc_cnt <= cyc_cnt + CNT_W'(1);
                        end
                    end

                    S_TE_ARM: begin
                        // te_en is up, give TE a few quiet cycles before pixels
                        if (cyc_cnt == ARM_LAST) begin
                            state       <= S_TE_PASS;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= '0;
                        end else begin
                            cyc_cnt <= cyc_cnt + CNT_W'(1);
                        end
                    end

                    S_TE_PASS: begin
                        if (mem_rd_addr == LAST_ADDR) begin
                            state       <= S_DRAIN;
                            mem_rd_en   <= 1'b0;
                            mem_rd_addr <= '0;
                            cyc_cnt     <= '0;
                        end else begin
                            mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
                        end
                    end

                    S_DRAIN: begin
                        if (out_count == FULL_CNT) begin
                            state      <= S_DONE;
                            frame_done <= 1'b1;
                        end else if (cyc_cnt == TMO_LAST) begin
                            state <= S_IDLE;
                            error <= 1'b1;
                            busy  <= 1'b0;
                            te_en <= 1'b0;
                        end else begin
                            cyc_cnt <= cyc_cnt + CNT_W'(1);
                        end
                    end

                    S_DONE: begin
                        state <= S_IDLE;
                        te_en <= 1'b0;
                        busy  <= 1'b0;
                    end

                    default: begin
                        state     <= S_IDLE;
                        mem_rd_en <= 1'b0;
                        te_en     <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ---- stage p1: frame-buffer data returns, beat presented downstream ----
    // A read issued in the abort cycle is dropped here so no stray beat leaks.
    always_ff @(posedge clk) begin
        if (rst)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= mem_rd_en && !abort;
    end

    // The buffer already holds its data for exactly the beat cycle, so the
    // pixel is forwarded directly and zeroed outside a beat.
    assign pixel_valid = vld_p1;
    assign pixel_out   = vld_p1 ? mem_rd_data : 24'd0;

endmodule

// File: tb/tb_dehaze_pass_sequencer.sv
module tb_dehaze_pass_sequencer;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int N   = W * H;
    localparam int AW  = 4;
    localparam int ARM = 2;
    localparam int TMO = 20;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [23:0]   mem_rd_data, pixel_out;
    logic          pixel_valid, te_en, ale_done, trans_valid;
    logic          busy, frame_done, error;
    logic [AW:0]   out_count;

    always #5 clk = ~clk;

    dehaze_pass_sequencer #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .ADDR_W    (AW),
        .ARM_CYCLES(ARM),
        .TIMEOUT   (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .pixel_out  (pixel_out),
        .pixel_valid(pixel_valid),
        .te_en      (te_en),
        .ale_done   (ale_done),
        .trans_valid(trans_valid),
        .busy       (busy),
        .frame_done (frame_done),
        .error      (error),
        .out_count  (out_count)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    logic          prev_en;
    logic [AW-1:0] prev_addr;

    typedef struct {
        logic          rd_en;
        logic [AW-1:0] addr;
        logic          pv;
        logic [23:0]   pdata;
        logic          te;
        logic          busy;
        logic          fd;
        logic          err;
        logic [AW:0]   ocnt;
        int            e;
        bit            win;
    } exp_t;

    typedef struct {
        int          d;
        int          lat;
        int          k;
        bit          sp;
        logic [AW:0] ocnt;
        logic        err;
        int          fd;
    } vec_t;

    function automatic logic [23:0] pix(input int a);
        return 24'(a * 32'h1F3A7 + 32'h5A5A5);
    endfunction

    // Address read at relative cycle r, or -1 when no read is expected.
    function automatic int rd_addr(input int r, input bit ok, input int p2, input int e);
        if (r < 0 || r >= e) return -1;
        if (r < N) return r;
        if (ok && r >= p2 && r < p2 + N) return r - p2;
        return -1;
    endfunction

    // Timeline of one frame. r=0 is the first cycle after start was taken.
    // d: ALE done delay after wait entry (-1 = never), lat: TE latency,
    // k: number of transmission beats TE produces.
    function automatic exp_t model(input int d, input int lat, input int k, input int r);
        exp_t x;
        int dd, a_arm, p2, dr, e, dn, a, b, t, c;
        bit ok, win;
        dd    = (d < 1) ? 1 : d;
        ok    = (d >= 0) && (dd <= TMO - 1);
        a_arm = N + dd + 1;
        p2    = a_arm + ARM;
        dr    = p2 + N;
        win   = 1'b0;
        if (!ok) begin
            e = N + TMO;
        end else if (k == N) begin
            dn = dr + lat + 1;
            if (dn - dr <= TMO - 1) begin
                win = 1'b1;
                e   = dn + 2;
            end else begin
                e = dr + TMO;
            end
        end else begin
            e = dr + TMO;
        end
        a       = rd_addr(r, ok, p2, e);
        b       = rd_addr(r - 1, ok, p2, e);
        x.rd_en = (a >= 0);
        x.addr  = x.rd_en ? AW'(a) : '0;
        x.pv    = (b >= 0);
        x.pdata = x.pv ? pix(b) : 24'd0;
        x.te    = ok && (r >= a_arm) && (r < e);
        x.busy  = (r < e);
        x.fd    = win && (r == e - 1);
        x.err   = !win && (r >= e);
        t       = (r < e) ? r : e;
        c       = t - (p2 + 1 + lat);
        if (c < 0) c = 0;
        if (c > k) c = k;
        x.ocnt  = ok ? (AW + 1)'(c) : '0;
        x.e     = e;
        x.win   = win;
        return x;
    endfunction

    function automatic logic [63:0] pack_exp(input exp_t x);
        return 64'({x.rd_en, x.addr, x.pv, x.pdata, x.te, x.busy, x.fd, x.err, x.ocnt});
    endfunction

    function automatic logic [63:0] pack_act();
        return 64'({mem_rd_en, (mem_rd_en ? mem_rd_addr : AW'(0)), pixel_valid, pixel_out,
                    te_en, busy, frame_done, error, out_count});
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; the frame buffer answers the read of the previous cycle.
    task automatic step();
        prev_en   = mem_rd_en;
        prev_addr = mem_rd_addr;
        @(posedge clk);
        #1;
        mem_rd_data = prev_en ? pix(int'(prev_addr)) : 24'($urandom);
        #1;
    endtask

    task automatic run_frame(input int d, input int lat, input int k, input bit sp,
                             input int rmax_in, output int fd_cnt,
                             output logic [AW:0] ocnt_f, output logic err_f);
        exp_t x;
        int   rmax, wobs, p1, te_beats;
        int   tq[$];
        x        = model(d, lat, k, 0);
        rmax     = (rmax_in < 0) ? x.e + 2 : rmax_in;
        wobs     = -1;
        p1       = 0;
        te_beats = 0;
        fd_cnt   = 0;
        tq.delete();
        ale_done    = 1'b0;
        trans_valid = 1'b0;
        start       = 1'b1;
        step();
        start = 1'b0;
        for (int r = 0; r <= rmax; r++) begin
            x = model(d, lat, k, r);
            check($sformatf("d%0d_l%0d_k%0d_cyc%0d", d, lat, k, r), pack_act(), pack_exp(x));
            fd_cnt += int'(frame_done);
            if (r == rmax) break;
            // ALE: done flag d cycles after the last pass-1 beat
            if (pixel_valid && !te_en) begin
                p1++;
                if (p1 == N) wobs = r;
            end
            ale_done = (d >= 0) && (wobs >= 0) && (r - wobs >= d);
            // TE: one transmission beat lat cycles after each pass-2 pixel
            if (pixel_valid && te_en && te_beats < k) begin
                tq.push_back(r + lat);
                te_beats++;
            end
            trans_valid = 1'b0;
            if (tq.size() > 0 && tq[0] == r) begin
                trans_valid = 1'b1;
                void'(tq.pop_front());
            end
            start = sp && (r < x.e) && ($urandom_range(0, 1) == 1);
            step();
        end
        ocnt_f      = out_count;
        err_f       = error;
        start       = 1'b0;
        ale_done    = 1'b0;
        trans_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[6];
        exp_t        z;
        int          fd;
        logic [AW:0] oc;
        logic        er;

        tbl[0] = '{d: 3,  lat: 2, k: 8, sp: 1'b0, ocnt: 5'd8, err: 1'b0, fd: 1};
        tbl[1] = '{d: -1, lat: 2, k: 8, sp: 1'b0, ocnt: 5'd0, err: 1'b1, fd: 0};
        tbl[2] = '{d: 3,  lat: 2, k: 8, sp: 1'b0, ocnt: 5'd8, err: 1'b0, fd: 1};
        tbl[3] = '{d: 0,  lat: 1, k: 8, sp: 1'b0, ocnt: 5'd8, err: 1'b0, fd: 1};
        tbl[4] = '{d: 2,  lat: 2, k: 7, sp: 1'b0, ocnt: 5'd7, err: 1'b1, fd: 0};
        tbl[5] = '{d: 1,  lat: 4, k: 8, sp: 1'b1, ocnt: 5'd8, err: 1'b0, fd: 1};

        z = '{rd_en: 1'b0, addr: '0, pv: 1'b0, pdata: 24'd0, te: 1'b0, busy: 1'b0,
              fd: 1'b0, err: 1'b0, ocnt: '0, e: 0, win: 1'b0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; ale_done = 1'b0; trans_valid = 1'b0;
        mem_rd_data = 24'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", pack_act(), pack_exp(z));
        rst = 1'b0;
        step();
        check("idle_after_reset", pack_act(), pack_exp(z));

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i].d, tbl[i].lat, tbl[i].k, tbl[i].sp, -1, fd, oc, er);
            check($sformatf("vec%0d_out_count", i), 64'(oc), 64'(tbl[i].ocnt));
            check($sformatf("vec%0d_error", i), 64'(er), 64'(tbl[i].err));
            check($sformatf("vec%0d_frame_done_pulses", i), 64'(fd), 64'(tbl[i].fd));
        end

        // abort on the 4th pass-1 read
        start = 1'b1;
        step();
        start = 1'b0;
        for (int r = 0; r < 4; r++) begin
            check($sformatf("abort_pre_cyc%0d", r), pack_act(), pack_exp(model(3, 2, 8, r)));
            if (r < 3) step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_next_cycle", 64'({mem_rd_en, busy, pixel_valid, frame_done, te_en, error}), 64'(0));
        for (int r = 0; r < 6; r++) begin
            step();
            check($sformatf("abort_quiet_%0d", r), 64'({mem_rd_en, pixel_valid, frame_done, busy}), 64'(0));
        end

        // reset in DRAIN with five beats counted, then a clean frame
        run_frame(3, 2, 5, 1'b0, 23, fd, oc, er);
        check("drain_count_before_rst", 64'(oc), 64'(5));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_in_drain", pack_act(), pack_exp(z));
        step();
        run_frame(3, 2, 8, 1'b0, -1, fd, oc, er);
        check("after_rst_out_count", 64'(oc), 64'(8));
        check("after_rst_frame_done_pulses", 64'(fd), 64'(1));

        // randomized frames against the timeline model
        for (int i = 0; i < 20; i++) begin
            int   d, lat, k;
            bit   sp;
            exp_t x;
            d   = int'($urandom_range(0, 13)) - 1;
            lat = int'($urandom_range(1, 4));
            k   = ($urandom_range(0, 3) == 0) ? N - int'($urandom_range(1, 2)) : N;
            sp  = ($urandom_range(0, 1) == 1);
            x   = model(d, lat, k, 0);
            run_frame(d, lat, k, sp, -1, fd, oc, er);
            check($sformatf("rnd%0d_frame_done_pulses", i), 64'(fd), 64'(x.win ? 1 : 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
